// File: rtl/arb_pkg.sv
// Shared types for the 4-way round-robin arbiter: requester count,
// FSM state encoding, requester index/vector types and a one-hot helper.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [1:0]         req_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  // One-hot vector with only bit idx set.
  function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans req starting at base and wrapping
// modulo 4, and returns the first set bit as a one-hot vector and an index.
module rr_pick4
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  req_idx_t base,
  output req_vec_t onehot,
  output req_idx_t idx,
  output logic     found
);

  logic [2*NUM_REQ-1:0] req_dbl;
  req_vec_t             rot;
  req_idx_t             off;

  // Rotate so that base lands at bit 0, then take the lowest set bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    req_dbl = {req, req};
    rot     = req_vec_t'(req_dbl >> base);
    off     = '0;
    found   = 1'b0;
    // Descending scan leaves the lowest set offset in off.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = req_idx_t'(i);
        found = 1'b1;
      end
    end
    // The 2-bit add wraps naturally, undoing the rotation modulo 4.
    idx    = found ? req_idx_t'(base + off) : '0;
    onehot = found ? idx_to_onehot(idx) : '0;
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// A holder keeps the grant until it drops its request or has held for
// MAX_HOLD cycles; then the pointer moves past it and arbitration restarts
// in the same cycle, so a waiting requester takes over without a bubble.
// All outputs are registered.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8  // legal range 1..255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       preempt
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MAX_CNT = cnt_t'(MAX_HOLD);

  state_t   state_q, state_d;
  req_idx_t ptr_q, ptr_d;
  cnt_t     hold_cnt_q, hold_cnt_d;
  req_vec_t gnt_q, gnt_d;
  req_idx_t gnt_id_q, gnt_id_d;
  logic     preempt_q, preempt_d;

  logic     hold_full;
  logic     keep;
  logic     timeout;
  req_idx_t pick_base;
  req_vec_t pick_onehot;
  req_idx_t pick_idx;
  logic     pick_found;

  // Classify the current cycle: holder keeps, holder times out, or re-arbitrate.
  always_comb begin
    hold_full = (hold_cnt_q == MAX_CNT);
    keep      = en && (state_q == GRANT) && req[gnt_id_q] && !hold_full;
    timeout   = en && (state_q == GRANT) && req[gnt_id_q] && hold_full;
    // Leaving a grant scans from just past the holder, making it lowest
    // priority; from IDLE the stored pointer is used unchanged.
    pick_base = (state_q == GRANT) ? req_idx_t'(gnt_id_q + 2'd1) : ptr_q;
  end

  rr_pick4 u_pick (
    .req    (req),
    .base   (pick_base),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Next-state logic for the FSM, rotation pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (!en) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d    = GRANT;
            hold_cnt_d = cnt_t'(1);
          end
        end
        GRANT: begin
          if (keep) begin
            hold_cnt_d = hold_cnt_q + cnt_t'(1);
          end else begin
            // Release or timeout: advance past the holder and re-arbitrate.
            ptr_d = pick_base;
            if (pick_found) begin
              state_d    = GRANT;
              hold_cnt_d = cnt_t'(1);
            end else begin
              state_d    = IDLE;
              hold_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Next values of the registered grant, grant index and preempt pulse.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    preempt_d = timeout;
    if (state_d == GRANT) begin
      if (keep) begin
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
      end else begin
        gnt_d    = pick_onehot;
        gnt_id_d = pick_idx;
      end
    end
  end

  // State register; reset clears everything without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Testbench for rr_arb4: three instances (MAX_HOLD 8, 4, 2) share inputs.
// Directed scenarios check literal expectations; a randomized phase checks
// all instances against a procedural round-robin reference model.
module tb_rr_arb4;

  localparam int N_DUT = 3;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       en      = 1'b0;
  logic [3:0] req     = 4'b0000;

  logic [3:0] gnt_a [N_DUT];
  logic [1:0] id_a  [N_DUT];
  logic       pre_a [N_DUT];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one entry per instance.
  bit m_busy   [N_DUT];
  int m_holder [N_DUT];
  int m_cnt    [N_DUT];
  int m_ptr    [N_DUT];
  bit m_pre    [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    rr_arb4 #(
      .MAX_HOLD ((g == 0) ? 8 : ((g == 1) ? 4 : 2))
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt_a[g]),
      .gnt_id  (id_a[g]),
      .preempt (pre_a[g])
    );
  end

  always #5 clock = ~clock;

  function automatic int max_of(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  // First requester at or after start (mod 4), or -1 if none.
  function automatic int scan_from(input int start, input logic [3:0] r);
    for (int j = 0; j < 4; j++) begin
      if (r[(start + j) % 4]) return (start + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_DUT; k++) begin
      m_busy[k] = 0; m_holder[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_pre[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the current en/req.
  task automatic model_step();
    int w;
    for (int k = 0; k < N_DUT; k++) begin
      m_pre[k] = 0;
      if (!en) begin
        m_busy[k] = 0;
        m_cnt[k]  = 0;
      end else if (!m_busy[k]) begin
        w = scan_from(m_ptr[k], req);
        if (w >= 0) begin
          m_busy[k] = 1; m_holder[k] = w; m_cnt[k] = 1;
        end
      end else if (req[m_holder[k]] && m_cnt[k] < max_of(k)) begin
        m_cnt[k]++;
      end else begin
        m_pre[k] = req[m_holder[k]];
        m_ptr[k] = (m_holder[k] + 1) % 4;
        w = scan_from(m_ptr[k], req);
        if (w >= 0) begin
          m_holder[k] = w; m_cnt[k] = 1;
        end else begin
          m_busy[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 4'b0000;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Reset state, first grant, asynchronous drop mid-grant, grant after reset.
  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; req = 4'b0000;
    @(negedge clock);
    for (int k = 0; k < N_DUT; k++) begin
      n_tests++;
      if ({gnt_a[k], id_a[k], pre_a[k]} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: gnt_id_pre got %b want %b", k, {gnt_a[k], id_a[k], pre_a[k]}, 7'b0);
      end
    end
    reset_n = 1'b1; en = 1'b1; req = 4'b1111;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_grant: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b0001, 2'd0, 1'b0});
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, 7'b0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int k = 0; k < N_DUT; k++) begin
      n_tests++;
      if ({gnt_a[k], id_a[k], pre_a[k]} !== {4'b0001, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL grant_after_reset[%0d]: gnt_id_pre got %b want %b", k, {gnt_a[k], id_a[k], pre_a[k]}, {4'b0001, 2'd0, 1'b0});
      end
    end
  endtask

  // Hold for three cycles, release to idle, next arbitration starts at 3.
  task automatic test_hold_release();
    do_reset();
    en = 1'b1; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_tests++;
      if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0100, 2'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: gnt_id_pre got %b want %b", i, {gnt_a[0], id_a[0], pre_a[0]}, {4'b0100, 2'd2, 1'b0});
      end
    end
    req = 4'b0000;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== 7'b0) begin
      n_fail++;
      $display("FAIL release_idle: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, 7'b0);
    end
    req = 4'b1111;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b1000, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL ptr_after_release: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b1000, 2'd3, 1'b0});
    end
  endtask

  // Release with another requester waiting hands over with no idle cycle.
  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; req = 4'b0001;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b0001, 2'd0, 1'b0});
    end
    req = 4'b0010;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0010, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_handover: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b0010, 2'd1, 1'b0});
    end
  endtask

  // MAX_HOLD=4 instance: 0 holds 4 cycles, preempt once, 1 holds 4 cycles.
  task automatic test_timeout();
    logic [3:0] eg;
    logic [1:0] ei;
    logic       ep;
    do_reset();
    en = 1'b1; req = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      eg = (i <= 4) ? 4'b0001 : 4'b0010;
      ei = (i <= 4) ? 2'd0 : 2'd1;
      ep = (i == 5);
      n_tests++;
      if ({gnt_a[1], id_a[1], pre_a[1]} !== {eg, ei, ep}) begin
        n_fail++;
        $display("FAIL timeout[%0d]: gnt_id_pre got %b want %b", i, {gnt_a[1], id_a[1], pre_a[1]}, {eg, ei, ep});
      end
    end
  endtask

  // MAX_HOLD=2 instance: sole requester re-granted, preempt every 2 cycles.
  task automatic test_sole_timeout();
    logic ep;
    do_reset();
    en = 1'b1; req = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      ep = (i >= 3) && (i % 2 == 1);
      n_tests++;
      if ({gnt_a[2], id_a[2], pre_a[2]} !== {4'b1000, 2'd3, ep}) begin
        n_fail++;
        $display("FAIL sole_timeout[%0d]: gnt_id_pre got %b want %b", i, {gnt_a[2], id_a[2], pre_a[2]}, {4'b1000, 2'd3, ep});
      end
    end
  endtask

  // MAX_HOLD=4 instance, all requesting: order 0,1,2,3,0 with 4 cycles each.
  task automatic test_fairness();
    logic [1:0] ei;
    logic       ep;
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      ei = 2'((i / 4) % 4);
      ep = (i > 0) && (i % 4 == 0);
      n_tests++;
      if ({gnt_a[1], id_a[1], pre_a[1]} !== {4'b0001 << ei, ei, ep}) begin
        n_fail++;
        $display("FAIL fairness[%0d]: gnt_id_pre got %b want %b", i, {gnt_a[1], id_a[1], pre_a[1]}, {4'b0001 << ei, ei, ep});
      end
    end
  endtask

  // Dropping en clears the grant; re-enabling resumes from the kept pointer.
  task automatic test_enable_drop();
    do_reset();
    en = 1'b1; req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    req = 4'b1111;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0010, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL en_setup: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b0010, 2'd1, 1'b0});
    end
    en = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== 7'b0) begin
      n_fail++;
      $display("FAIL en_drop: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, 7'b0);
    end
    en = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({gnt_a[0], id_a[0], pre_a[0]} !== {4'b0010, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL en_resume: gnt_id_pre got %b want %b", {gnt_a[0], id_a[0], pre_a[0]}, {4'b0010, 2'd1, 1'b0});
    end
  endtask

  // Randomized en/req/reset traffic compared against the reference model.
  task automatic test_random();
    logic [3:0] eg;
    logic [1:0] ei;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_n = ($urandom_range(99) != 0);
      en      = ($urandom_range(9) != 0);
      if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
      if (!reset_n) model_reset();
      else          model_step();
      @(negedge clock);
      for (int k = 0; k < N_DUT; k++) begin
        eg = m_busy[k] ? (4'b0001 << m_holder[k]) : 4'b0000;
        ei = m_busy[k] ? 2'(m_holder[k]) : 2'd0;
        n_tests++;
        if ({gnt_a[k], id_a[k], pre_a[k]} !== {eg, ei, m_pre[k]}) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: gnt_id_pre got %b want %b", cyc, k, {gnt_a[k], id_a[k], pre_a[k]}, {eg, ei, m_pre[k]});
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_back_to_back();
    test_timeout();
    test_sole_timeout();
    test_fairness();
    test_enable_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
